// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard and its operand matchers.
package hazard_pkg;

    // One tracked backend slot: who is in flight and what it will write.
    typedef struct packed {
        logic       valid;  // slot holds a real instruction
        logic [4:0] rd;     // destination register (0 = no write)
        logic       late;   // load whose result does not exist yet
        logic       csr;    // instruction writes a CSR
    } slot_t;

    // Architectural zero register: never a true dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Forwarding select value meaning "read the register file".
    localparam int FWD_REGFILE = 0;

    // Bubble entry used for cleared or empty slots.
    localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/hazard_match.sv
// Priority encoder for one source operand: finds the youngest (lowest-index)
// valid slot whose destination equals the operand, and reports whether that
// producer's result is still late.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  slot_t [DEPTH-1:0] slots,
    input  logic [4:0]        rs,
    output logic [SW-1:0]     index,
    output logic              late
);

    // csr bits ride along in the slot array but play no part in operand matching.
    logic [DEPTH-1:0] unused_csr;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unused
        assign unused_csr[gi] = slots[gi].csr;
    end

    // Scan oldest to youngest so the youngest matching producer is the one kept.
    always_comb begin
        index = SW'(FWD_REGFILE);
        late  = 1'b0;
        if (rs != REG_ZERO) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (slots[k].valid && (slots[k].rd == rs)) begin
                    index = SW'(k + 1);
                    late  = slots[k].late;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadows the destination registers of every in-flight
// instruction from execute (slot 1) to writeback (slot DEPTH), and produces
// forwarding selects, load-use/CSR/backend stalls, flush invalidates and a
// saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int DEPTH      = 3,
    parameter  int LATE_SLOT  = 2,
    parameter  int FORWARDING = 1,
    localparam int SW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       rs1_address_decode,
    input  logic [4:0]       rs2_address_decode,
    input  logic [4:0]       rd_address_decode,
    input  logic             load_decode,
    input  logic             csr_write_decode,
    input  logic             valid_decode,
    input  logic             fetch_ready,
    input  logic             mem_ready,
    input  logic             flush_valid,
    input  logic [SW-1:0]    flush_stage,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             stall_backend,
    output logic             invalidate_fetch,
    output logic             invalidate_decode,
    output logic [DEPTH-1:0] invalidate_stage,
    output logic [SW-1:0]    fwd_rs1,
    output logic [SW-1:0]    fwd_rs2,
    output logic [31:0]      stall_cycles
);

    // Slot state: index 0 is slot 1 (execute), index DEPTH-1 is writeback.
    slot_t [DEPTH-1:0] slot_reg;
    slot_t [DEPTH-1:0] slot_next;
    // Slot state after younger-than-flush entries are squashed.
    slot_t [DEPTH-1:0] slot_kept;

    logic [31:0] stall_cycles_reg;
    logic [31:0] stall_cycles_next;

    // Per-operand match results (0 = rs1, 1 = rs2).
    logic [1:0][4:0]    operand_rs;
    logic [1:0][SW-1:0] match_index;
    logic [1:0]         match_late;
    logic [1:0]         match_hit;
    logic [1:0]         operand_hazard;
    logic [1:0][SW-1:0] fwd_sel;

    logic [DEPTH-1:0] csr_pending;
    logic             csr_busy;
    logic             issue;
    slot_t            decode_entry;

    assign operand_rs[0] = rs1_address_decode;
    assign operand_rs[1] = rs2_address_decode;

    // ------------------------------------------------------------------
    // Operand matching and per-operand hazard decision
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
        hazard_match #(
            .DEPTH (DEPTH),
            .SW    (SW)
        ) u_match (
            .slots (slot_reg),
            .rs    (operand_rs[gi]),
            .index (match_index[gi]),
            .late  (match_late[gi])
        );

        assign match_hit[gi] = (match_index[gi] != SW'(FWD_REGFILE));

        // With bypass only an unavailable (late) result blocks decode; without
        // bypass any producer ahead of writeback blocks, since writeback itself
        // is covered by register-file write-through.
        assign operand_hazard[gi] = (FORWARDING != 0)
                                  ? (match_hit[gi] && match_late[gi])
                                  : (match_hit[gi] && (match_index[gi] != SW'(DEPTH)));

        assign fwd_sel[gi] = (FORWARDING != 0) ? match_index[gi] : SW'(FWD_REGFILE);
    end

    assign fwd_rs1 = fwd_sel[0];
    assign fwd_rs2 = fwd_sel[1];

    // ------------------------------------------------------------------
    // Per-slot CSR tracking, flush invalidates and next-state shifting
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign csr_pending[gi] = slot_reg[gi].valid && slot_reg[gi].csr;

        // Slots up to and including the flushing stage receive a bubble.
        assign invalidate_stage[gi] = flush_valid && (SW'(gi + 1) <= flush_stage);

        // Instructions younger than the flushing one are dropped before any
        // shift, so they never leak into the flushing slot's successor.
        assign slot_kept[gi] = (flush_valid && (SW'(gi + 1) < flush_stage))
                             ? SLOT_EMPTY : slot_reg[gi];

        if (gi == 0) begin : g_head
            // Execute slot takes the decode instruction on issue, else a bubble.
            assign slot_next[gi] = mem_ready
                                 ? (issue ? decode_entry : SLOT_EMPTY)
                                 : slot_kept[gi];
        end else begin : g_body
            slot_t aged;

            // A load's result exists once it has reached LATE_SLOT.
            assign aged.valid = slot_kept[gi-1].valid;
            assign aged.rd    = slot_kept[gi-1].rd;
            assign aged.late  = slot_kept[gi-1].late && ((gi + 1) < LATE_SLOT);
            assign aged.csr   = slot_kept[gi-1].csr;

            assign slot_next[gi] = mem_ready ? aged : slot_kept[gi];
        end
    end

    assign csr_busy = |csr_pending;

    // Entry describing the decode instruction as it would enter execute.
    assign decode_entry.valid = 1'b1;
    assign decode_entry.rd    = rd_address_decode;
    assign decode_entry.late  = load_decode && (LATE_SLOT > 1);
    assign decode_entry.csr   = csr_write_decode;

    // ------------------------------------------------------------------
    // Stall, issue and invalidate outputs (zero-latency combinational)
    // ------------------------------------------------------------------
    // Stalls combine operand hazards, CSR serialisation and backend back-pressure.
    always_comb begin
        stall_backend     = !mem_ready;
        stall_decode      = operand_hazard[0] || operand_hazard[1] || csr_busy || !mem_ready;
        stall_fetch       = stall_decode || !fetch_ready;
        issue             = valid_decode && !stall_decode && !flush_valid;
        invalidate_fetch  = flush_valid;
        invalidate_decode = flush_valid;
    end

    // Saturating count of cycles in which decode is stalled.
    always_comb begin
        stall_cycles_next = stall_cycles_reg;
        if (stall_decode && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
            stall_cycles_next = stall_cycles_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;

    // ------------------------------------------------------------------
    // State registers; reset empties every slot immediately, no draining.
    // ------------------------------------------------------------------
    // Slot shadow and performance counter update on the rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_reg         <= '0;
            stall_cycles_reg <= '0;
        end else begin
            slot_reg         <= slot_next;
            stall_cycles_reg <= stall_cycles_next;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a bypassing build (inst 0) and a
// non-bypassing build (inst 1) share stimulus and are each compared every cycle
// against an in-flight-instruction model derived from the pipeline rules.
module tb_hazard_scoreboard;

    localparam int D  = 3;
    localparam int LS = 2;
    localparam int SW = $clog2(D + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [4:0]    rs1, rs2, rd;
    logic          load, csr, valid, fetch_ready, mem_ready, flush_valid;
    logic [SW-1:0] flush_stage;

    logic          sf [2];
    logic          sd [2];
    logic          sb [2];
    logic          inv_f [2];
    logic          inv_d [2];
    logic [D-1:0]  inv_s [2];
    logic [SW-1:0] f1 [2];
    logic [SW-1:0] f2 [2];
    logic [31:0]   sc [2];

    hazard_scoreboard #(.DEPTH(D), .LATE_SLOT(LS), .FORWARDING(1)) u_fwd (
        .clk(clk), .reset_n(reset_n),
        .rs1_address_decode(rs1), .rs2_address_decode(rs2), .rd_address_decode(rd),
        .load_decode(load), .csr_write_decode(csr), .valid_decode(valid),
        .fetch_ready(fetch_ready), .mem_ready(mem_ready),
        .flush_valid(flush_valid), .flush_stage(flush_stage),
        .stall_fetch(sf[0]), .stall_decode(sd[0]), .stall_backend(sb[0]),
        .invalidate_fetch(inv_f[0]), .invalidate_decode(inv_d[0]),
        .invalidate_stage(inv_s[0]), .fwd_rs1(f1[0]), .fwd_rs2(f2[0]),
        .stall_cycles(sc[0])
    );

    hazard_scoreboard #(.DEPTH(D), .LATE_SLOT(LS), .FORWARDING(0)) u_nofwd (
        .clk(clk), .reset_n(reset_n),
        .rs1_address_decode(rs1), .rs2_address_decode(rs2), .rd_address_decode(rd),
        .load_decode(load), .csr_write_decode(csr), .valid_decode(valid),
        .fetch_ready(fetch_ready), .mem_ready(mem_ready),
        .flush_valid(flush_valid), .flush_stage(flush_stage),
        .stall_fetch(sf[1]), .stall_decode(sd[1]), .stall_backend(sb[1]),
        .invalidate_fetch(inv_f[1]), .invalidate_decode(inv_d[1]),
        .invalidate_stage(inv_s[1]), .fwd_rs1(f1[1]), .fwd_rs2(f2[1]),
        .stall_cycles(sc[1])
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each model keeps the instructions in flight by pipeline position; whether a
    // load's data exists is derived from its position, not stored.
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       load;
        bit       csr;
    } instr_t;

    instr_t      pipe [2][1:D];
    int unsigned stall_count [2];
    bit          exp_stall [2];

    function automatic void clear_model();
        for (int n = 0; n < 2; n++) begin
            for (int k = 1; k <= D; k++) pipe[n][k] = '{default: 0};
            stall_count[n] = 0;
        end
    endfunction

    function automatic int find_match(input int n, input logic [4:0] rs);
        if (rs == 5'd0) return 0;
        for (int k = 1; k <= D; k++)
            if (pipe[n][k].valid && pipe[n][k].rd == rs) return k;
        return 0;
    endfunction

    function automatic bit operand_blocks(input int n, input logic [4:0] rs);
        int k;
        k = find_match(n, rs);
        if (k == 0) return 1'b0;
        if (n == 0) return pipe[n][k].load && (k < LS);
        return k < D;
    endfunction

    function automatic bit csr_in_flight(input int n);
        for (int k = 1; k <= D; k++)
            if (pipe[n][k].valid && pipe[n][k].csr) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_dut(input int n);
        string        p;
        bit           s;
        logic [D-1:0] inv;
        p = (n == 0) ? "fwd1" : "fwd0";
        s = operand_blocks(n, rs1) || operand_blocks(n, rs2) || csr_in_flight(n) || !mem_ready;
        exp_stall[n] = s;
        for (int k = 1; k <= D; k++) inv[k-1] = flush_valid && (k <= int'(flush_stage));
        check_value({p, ".stall_decode"}, 32'(sd[n]), 32'(s));
        check_value({p, ".stall_fetch"}, 32'(sf[n]), 32'(s || !fetch_ready));
        check_value({p, ".stall_backend"}, 32'(sb[n]), 32'(!mem_ready));
        check_value({p, ".inv_fetch"}, 32'(inv_f[n]), 32'(flush_valid));
        check_value({p, ".inv_decode"}, 32'(inv_d[n]), 32'(flush_valid));
        check_value({p, ".inv_stage"}, 32'(inv_s[n]), 32'(inv));
        check_value({p, ".fwd_rs1"}, 32'(f1[n]), (n == 0) ? 32'(find_match(n, rs1)) : 32'd0);
        check_value({p, ".fwd_rs2"}, 32'(f2[n]), (n == 0) ? 32'(find_match(n, rs2)) : 32'd0);
        check_value({p, ".stall_cycles"}, sc[n], stall_count[n]);
    endtask

    function automatic void advance_model(input int n);
        bit issue;
        issue = valid && !exp_stall[n] && !flush_valid;
        if (flush_valid)
            for (int k = 1; k < int'(flush_stage); k++) pipe[n][k] = '{default: 0};
        if (mem_ready) begin
            for (int k = D; k >= 2; k--) pipe[n][k] = pipe[n][k-1];
            if (issue) pipe[n][1] = '{valid: 1'b1, rd: rd, load: load, csr: csr};
            else       pipe[n][1] = '{default: 0};
        end
        if (exp_stall[n] && stall_count[n] != 32'hFFFF_FFFF) stall_count[n]++;
    endfunction

    // ---------------- cycle helpers ----------------
    task automatic sample();
        @(negedge clk);
        if (!reset_n) clear_model();
        check_dut(0);
        check_dut(1);
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset_n) begin
            advance_model(0);
            advance_model(1);
        end else begin
            clear_model();
        end
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic set_dec(input bit v, input int a, input int b, input int d, input bit ld, input bit c);
        valid = v;
        rs1   = 5'(a);
        rs2   = 5'(b);
        rd    = 5'(d);
        load  = ld;
        csr   = c;
    endtask

    int unsigned base_cnt;

    initial begin
        reset_n     = 1'b0;
        fetch_ready = 1'b1;
        mem_ready   = 1'b1;
        flush_valid = 1'b0;
        flush_stage = SW'(1);
        set_dec(0, 0, 0, 0, 0, 0);
        clear_model();

        $display("phase: reset");
        step();
        fetch_ready = 1'b0;
        step();
        fetch_ready = 1'b1;
        reset_n = 1'b1;
        step();

        $display("phase: back-to-back alu dependency");
        set_dec(1, 0, 0, 5, 0, 0); step();
        set_dec(1, 5, 0, 6, 0, 0); sample();
        check_value("alu.fwd_rs1", 32'(f1[0]), 32'd1);
        check_value("alu.no_stall", 32'(sd[0]), 32'd0);
        advance();
        set_dec(0, 0, 0, 0, 0, 0); repeat (4) step();

        $display("phase: load-use");
        set_dec(1, 0, 0, 7, 1, 0); step();
        set_dec(1, 7, 0, 8, 0, 0); sample();
        check_value("lu.stall", 32'(sd[0]), 32'd1);
        advance();
        sample();
        check_value("lu.fwd_rs1", 32'(f1[0]), 32'd2);
        check_value("lu.released", 32'(sd[0]), 32'd0);
        check_value("lu.stall_cycles", sc[0], 32'd1);
        advance();
        set_dec(0, 0, 0, 0, 0, 0); repeat (4) step();

        $display("phase: csr serialisation");
        set_dec(1, 0, 0, 0, 0, 1); step();
        set_dec(1, 0, 0, 3, 0, 0);
        repeat (3) begin
            sample();
            check_value("csr.stall", 32'(sd[0]), 32'd1);
            advance();
        end
        sample();
        check_value("csr.release", 32'(sd[0]), 32'd0);
        advance();
        set_dec(0, 0, 0, 0, 0, 0); repeat (4) step();

        $display("phase: branch flush");
        set_dec(1, 0, 0, 9, 1, 0); step();
        set_dec(1, 9, 0, 10, 0, 0);
        flush_valid = 1'b1;
        flush_stage = SW'(2);
        sample();
        check_value("flush.inv_stage", 32'(inv_s[0]), 32'b011);
        check_value("flush.inv_fetch", 32'(inv_f[0]), 32'd1);
        advance();
        flush_valid = 1'b0;
        sample();
        check_value("flush.released", 32'(sd[0]), 32'd0);
        advance();
        set_dec(0, 0, 0, 0, 0, 0); repeat (4) step();

        $display("phase: mem_ready low during load-use");
        base_cnt = stall_count[0];
        set_dec(1, 0, 0, 7, 1, 0); step();
        set_dec(1, 7, 0, 8, 0, 0);
        mem_ready = 1'b0;
        repeat (4) begin
            sample();
            check_value("mem.stall_backend", 32'(sb[0]), 32'd1);
            advance();
        end
        mem_ready = 1'b1;
        step();
        sample();
        check_value("mem.fwd_rs1", 32'(f1[0]), 32'd2);
        check_value("mem.stall_cycles", sc[0], base_cnt + 32'd5);
        advance();
        set_dec(0, 0, 0, 0, 0, 0); repeat (4) step();

        $display("phase: no-bypass build and reset pulse");
        set_dec(1, 0, 0, 5, 0, 0); step();
        set_dec(1, 5, 0, 6, 0, 0);
        repeat (2) begin
            sample();
            check_value("nofwd.stall", 32'(sd[1]), 32'd1);
            check_value("nofwd.fwd_rs1", 32'(f1[1]), 32'd0);
            advance();
        end
        sample();
        check_value("nofwd.release", 32'(sd[1]), 32'd0);
        advance();
        set_dec(1, 6, 0, 11, 1, 0); step();
        reset_n = 1'b0;
        sample();
        check_value("rst.stall_cycles", sc[1], 32'd0);
        check_value("rst.fwd_rs1", 32'(f1[0]), 32'd0);
        advance();
        reset_n = 1'b1;
        step();

        $display("phase: random traffic");
        for (int i = 0; i < 3000; i++) begin
            valid       = ($urandom_range(0, 9) < 8);
            rs1         = 5'($urandom_range(0, 7));
            rs2         = 5'($urandom_range(0, 7));
            rd          = 5'($urandom_range(0, 7));
            load        = ($urandom_range(0, 3) == 0);
            csr         = ($urandom_range(0, 19) == 0);
            fetch_ready = ($urandom_range(0, 7) != 0);
            mem_ready   = ($urandom_range(0, 6) != 0);
            flush_valid = ($urandom_range(0, 11) == 0);
            flush_stage = SW'($urandom_range(1, D));
            reset_n     = ($urandom_range(0, 499) != 0);
            step();
        end
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
